mcpu_seq_ctrl: RTL and testbench

Multi-cycle control sequencer for the 32-bit CPU datapath (register file, ALU, PC). It fetches an instruction from instruction memory into an instruction register and decodes operand and destination selection. It then sequences EXEC and writeback, pulsing the register-file write enable and the PC increment once per instruction. It also arbitrates the register-file write port between the CPU writeback and a debug requester.

---
 rtl/mcpu_pkg.sv | 30 +++
 rtl/mcpu_fetch_tmo.sv | 26 ++
 rtl/mcpu_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_mcpu_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared types and constants for the multi-cycle CPU control sequencer.
package mcpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_DBG    = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [5:0] OPC_RTYPE   = 6'h00;
    localparam logic [5:0] HALT_OP_DEF = 6'h3F;

    // Instruction field positions
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 26;
    localparam int unsigned RT_HI  = 20;
    localparam int unsigned RT_LO  = 16;
    localparam int unsigned RD_HI  = 15;
    localparam int unsigned RD_LO  = 11;

    function automatic logic [5:0] opcode_of(input logic [31:0] inst);
        return inst[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/mcpu_fetch_tmo.sv
// Fetch timeout counter: counts FETCH cycles without IMEM_RDY, flags the last allowed one.
module mcpu_fetch_tmo #(
    parameter int unsigned TMO = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expire = (cnt == 8'(TMO - 1));

endmodule

// File: rtl/mcpu_seq_ctrl.sv
// Multi-cycle control sequencer: fetch/decode/exec/writeback with debug write-port arbitration.
module mcpu_seq_ctrl
    import mcpu_pkg::*;
#(
    parameter logic [5:0]  HALT_OP   = HALT_OP_DEF,
    parameter int unsigned FETCH_TMO = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic        IMEM_REQ,
    input  logic        IMEM_RDY,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] INST,
    output logic        ALUSRC,
    output logic        DES_SEL,
    output logic        REG_WE,
    output logic        PC_INC,
    input  logic        DBG_REQ,
    output logic        DBG_GNT,
    output logic        BUSY,
    output logic        HALTED,
    output logic        ERR
);

    state_t state;
    state_t state_nxt;
    logic   tmo_clr;
    logic   tmo_inc;
    logic   tmo_exp;
    logic   fetch_hs;

    assign fetch_hs = (state == S_FETCH) && IMEM_RDY;
    assign tmo_inc  = (state == S_FETCH) && !IMEM_RDY;
    assign tmo_clr  = !tmo_inc;

    mcpu_fetch_tmo #(
        .TMO(FETCH_TMO)
    ) u_fetch_tmo (
        .clk    (CLK),
        .rst_n  (RST),
        .clr    (tmo_clr),
        .inc    (tmo_inc),
        .expire (tmo_exp)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            INST    <= '0;
            ALUSRC  <= 1'b0;
            DES_SEL <= 1'b0;
        end else begin
            if (fetch_hs) begin
                INST <= IMEM_DATA;
            end
            if (state == S_DECODE) begin
                ALUSRC  <= (opcode_of(INST) != OPC_RTYPE);
                DES_SEL <= (opcode_of(INST) != OPC_RTYPE);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        IMEM_REQ  = 1'b0;
        REG_WE    = 1'b0;
        PC_INC    = 1'b0;
        DBG_GNT   = 1'b0;
        BUSY      = 1'b0;
        HALTED    = 1'b0;
        ERR       = 1'b0;
        case (state)
            S_IDLE: begin
                DBG_GNT = DBG_REQ;
                if (START && !DBG_REQ) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                IMEM_REQ = 1'b1;
                BUSY     = 1'b1;
                // A handshake on the final timeout cycle still counts as a fetch
                if (IMEM_RDY) begin
                    state_nxt = S_DECODE;
                end else if (tmo_exp) begin
                    state_nxt = S_ERROR;
                end
            end
            S_DECODE: begin
                BUSY      = 1'b1;
                state_nxt = (opcode_of(INST) == HALT_OP) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                BUSY      = 1'b1;
                state_nxt = S_WB;
            end
            S_WB: begin
                BUSY      = 1'b1;
                REG_WE    = 1'b1;
                PC_INC    = 1'b1;
                state_nxt = DBG_REQ ? S_DBG : S_FETCH;
            end
            S_DBG: begin
                DBG_GNT = DBG_REQ;
                if (!DBG_REQ) begin
                    state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                HALTED  = 1'b1;
                DBG_GNT = DBG_REQ;
            end
            S_ERROR: begin
                ERR = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Grant must read 0 while reset is held, even if debug is requesting
        if (!RST) begin
            DBG_GNT = 1'b0;
        end
    end

endmodule

// File: tb/tb_mcpu_seq_ctrl.sv
// Self-checking bench for mcpu_seq_ctrl: cycle model compared every cycle plus directed literal checks.
module tb_mcpu_seq_ctrl;

    localparam int TMO = 15;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        IMEM_REQ;
    logic        IMEM_RDY = 1'b0;
    logic [31:0] IMEM_DATA = 32'h0;
    logic [31:0] INST;
    logic        ALUSRC;
    logic        DES_SEL;
    logic        REG_WE;
    logic        PC_INC;
    logic        DBG_REQ = 1'b0;
    logic        DBG_GNT;
    logic        BUSY;
    logic        HALTED;
    logic        ERR;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    mcpu_seq_ctrl #(
        .HALT_OP   (6'h3F),
        .FETCH_TMO (TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .IMEM_REQ  (IMEM_REQ),
        .IMEM_RDY  (IMEM_RDY),
        .IMEM_DATA (IMEM_DATA),
        .INST      (INST),
        .ALUSRC    (ALUSRC),
        .DES_SEL   (DES_SEL),
        .REG_WE    (REG_WE),
        .PC_INC    (PC_INC),
        .DBG_REQ   (DBG_REQ),
        .DBG_GNT   (DBG_GNT),
        .BUSY      (BUSY),
        .HALTED    (HALTED),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode plus step index within an instruction (0 fetch .. 3 writeback)
    localparam int M_IDLE = 0, M_RUN = 1, M_DBG = 2, M_HALT = 3, M_ERR = 4;
    int          m_mode = M_IDLE;
    int          m_step = 0;
    int          m_wait = 0;
    logic [31:0] m_inst = 32'h0;
    logic        m_src  = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_mode <= M_IDLE;
            m_step <= 0;
            m_wait <= 0;
            m_inst <= 32'h0;
            m_src  <= 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (START && !DBG_REQ) begin
                    m_mode <= M_RUN;
                    m_step <= 0;
                    m_wait <= 0;
                end
                M_RUN: begin
                    if (m_step == 0) begin
                        if (IMEM_RDY) begin
                            m_inst <= IMEM_DATA;
                            m_wait <= 0;
                            m_step <= 1;
                        end else if (m_wait == TMO - 1) begin
                            m_mode <= M_ERR;
                        end else begin
                            m_wait <= m_wait + 1;
                        end
                    end else if (m_step == 1) begin
                        m_src <= (m_inst[31:26] != 6'd0);
                        if (m_inst[31:26] == 6'h3F) m_mode <= M_HALT;
                        else m_step <= 2;
                    end else if (m_step == 2) begin
                        m_step <= 3;
                    end else begin
                        m_step <= 0;
                        m_wait <= 0;
                        if (DBG_REQ) m_mode <= M_DBG;
                    end
                end
                M_DBG: if (!DBG_REQ) begin
                    m_mode <= M_RUN;
                    m_step <= 0;
                    m_wait <= 0;
                end
                default: ;
            endcase
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("m_imem_req", {31'd0, IMEM_REQ}, {31'd0, (m_mode == M_RUN && m_step == 0)});
            check("m_reg_we",   {31'd0, REG_WE},   {31'd0, (m_mode == M_RUN && m_step == 3)});
            check("m_pc_inc",   {31'd0, PC_INC},   {31'd0, (m_mode == M_RUN && m_step == 3)});
            check("m_busy",     {31'd0, BUSY},     {31'd0, (m_mode == M_RUN)});
            check("m_halted",   {31'd0, HALTED},   {31'd0, (m_mode == M_HALT)});
            check("m_err",      {31'd0, ERR},      {31'd0, (m_mode == M_ERR)});
            check("m_dbg_gnt",  {31'd0, DBG_GNT},
                  {31'd0, (RST && DBG_REQ && (m_mode == M_IDLE || m_mode == M_DBG || m_mode == M_HALT))});
            check("m_inst",     INST,              m_inst);
            check("m_alusrc",   {31'd0, ALUSRC},   {31'd0, m_src});
            check("m_des_sel",  {31'd0, DES_SEL},  {31'd0, m_src});
            check("inv_we_gnt", {31'd0, (REG_WE & DBG_GNT)}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        START = 1'b0;
        DBG_REQ = 1'b0;
        tick(1);
        RST = 1'b1;
    endtask

    initial begin
        int cnt;

        // Reset state
        tick(1);
        cmp_en = 1'b1;
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_inst", INST, 32'd0);
        check("rst_req",  {31'd0, IMEM_REQ}, 32'd0);
        tick(1);
        RST = 1'b1;

        // R-type, immediate RDY
        IMEM_DATA = 32'h00221800;
        IMEM_RDY  = 1'b1;
        START     = 1'b1;
        tick(1);
        check("r_c1_req", {31'd0, IMEM_REQ}, 32'd1);
        START = 1'b0;
        tick(1);
        check("r_c2_inst", INST, 32'h00221800);
        tick(1);
        check("r_c3_alusrc", {31'd0, ALUSRC}, 32'd0);
        check("r_c3_dessel", {31'd0, DES_SEL}, 32'd0);
        tick(1);
        check("r_c4_we",  {31'd0, REG_WE}, 32'd1);
        check("r_c4_inc", {31'd0, PC_INC}, 32'd1);
        tick(1);
        check("r_c5_req", {31'd0, IMEM_REQ}, 32'd1);

        // Asynchronous reset in the middle of writeback
        tick(3);
        check("rwb_pre_we", {31'd0, REG_WE}, 32'd1);
        RST = 1'b0;
        #1;
        check("rwb_we",   {31'd0, REG_WE}, 32'd0);
        check("rwb_inst", INST, 32'd0);
        check("rwb_busy", {31'd0, BUSY}, 32'd0);
        tick(1);
        RST = 1'b1;

        // Immediate-type instruction
        IMEM_DATA = 32'h20220005;
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(2);
        check("i_alusrc", {31'd0, ALUSRC}, 32'd1);
        check("i_dessel", {31'd0, DES_SEL}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (REG_WE) cnt++;
        end
        check("i_we_pulses", cnt, 32'd1);
        do_reset();

        // HALT opcode
        IMEM_DATA = 32'hFC000000;
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(2);
        check("h_halted", {31'd0, HALTED}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            START = i[0];
            tick(1);
            if (REG_WE || PC_INC || BUSY) cnt++;
        end
        START = 1'b0;
        check("h_no_activity", cnt, 32'd0);
        check("h_still", {31'd0, HALTED}, 32'd1);
        DBG_REQ = 1'b1;
        #1;
        check("h_gnt", {31'd0, DBG_GNT}, 32'd1);
        DBG_REQ = 1'b0;
        do_reset();

        // Fetch timeout
        IMEM_RDY = 1'b0;
        START = 1'b1;
        tick(1);
        START = 1'b0;
        cnt = IMEM_REQ ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (IMEM_REQ) cnt++;
            else break;
        end
        check("t_fetch_cycles", cnt, TMO);
        check("t_err", {31'd0, ERR}, 32'd1);
        check("t_req", {31'd0, IMEM_REQ}, 32'd0);
        START = 1'b1;
        DBG_REQ = 1'b1;
        tick(3);
        check("t_sticky", {31'd0, ERR}, 32'd1);
        check("t_no_gnt", {31'd0, DBG_GNT}, 32'd0);
        do_reset();

        // RDY arriving on the final allowed fetch cycle
        IMEM_DATA = 32'h00221800;
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(14);
        IMEM_RDY = 1'b1;
        tick(1);
        check("tl_err",  {31'd0, ERR}, 32'd0);
        check("tl_inst", INST, 32'h00221800);
        check("tl_busy", {31'd0, BUSY}, 32'd1);

        // Debug request raised during EXEC
        tick(1);
        DBG_REQ = 1'b1;
        #1;
        check("d_exec_gnt", {31'd0, DBG_GNT}, 32'd0);
        tick(1);
        check("d_wb_we",  {31'd0, REG_WE}, 32'd1);
        check("d_wb_gnt", {31'd0, DBG_GNT}, 32'd0);
        tick(1);
        check("d_dbg_gnt", {31'd0, DBG_GNT}, 32'd1);
        check("d_dbg_req", {31'd0, IMEM_REQ}, 32'd0);
        DBG_REQ = 1'b0;
        #1;
        check("d_gnt_drop", {31'd0, DBG_GNT}, 32'd0);
        tick(1);
        check("d_fetch", {31'd0, IMEM_REQ}, 32'd1);
        do_reset();

        // Debug beats START in IDLE
        DBG_REQ = 1'b1;
        START = 1'b1;
        tick(2);
        check("ip_busy", {31'd0, BUSY}, 32'd0);
        check("ip_gnt",  {31'd0, DBG_GNT}, 32'd1);
        DBG_REQ = 1'b0;
        tick(1);
        check("ip_fetch", {31'd0, IMEM_REQ}, 32'd1);
        START = 1'b0;
        tick(2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
